shift_exec_pipe: RTL and testbench

Two-stage pipelined shift/rotate execute unit for the 16-bit WISC datapath. It accepts shift micro-ops from decode over a valid/ready handshake and buffers the operands in stage A. The 16-bit right-shift network computes the result between stage A and stage B, and left operations reuse it by bit-reversing the operand and the result. The result, destination tag and zero flag are delivered to writeback over a second valid/ready handshake.

---
 rtl/shift_exec_pipe.sv | 146 ++++++++++++++
 tb/tb_shift_exec_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_pipe.sv
// Two-stage shift/rotate execute unit: stage A buffers the op, stage B holds the result for writeback.
// Optional arithmetic right shift (SRA via SRL + in_arith) is enabled by defining SHIFT_ARITH_EN.
module shift_exec_pipe #(
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [3:0]       in_count,
    input  logic [1:0]       in_op,
    input  logic             in_arith,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRL = 2'b11
    } shift_op_e;

    logic             a_valid_q;
    logic [15:0]      a_data_q;
    logic [3:0]       a_count_q;
    shift_op_e        a_op_q;
    logic [TAG_W-1:0] a_tag_q;

    logic             b_valid_q;
    logic [15:0]      b_data_q;
    logic [TAG_W-1:0] b_tag_q;
    logic             b_zero_q;

    logic             advance_b;
    logic             advance_a;
    logic             accept;
    logic             fill_bit;
    logic [15:0]      shift_d;

`ifdef SHIFT_ARITH_EN
    logic a_arith_q;
    assign fill_bit = a_arith_q && (a_op_q == OP_SRL) && a_data_q[15];
`else
    logic unused_arith;
    assign unused_arith = in_arith;
    assign fill_bit     = 1'b0;
`endif

    assign advance_b = !b_valid_q || out_ready;
    assign advance_a = a_valid_q && advance_b;
    assign in_ready  = !flush && (!a_valid_q || advance_b);
    assign accept    = in_valid && in_ready;

    function automatic logic [15:0] rev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

    // Left ops reuse the right-shift network by reversing operand and result.
    logic        is_left;
    logic        rotate;
    logic [15:0] net_in;
    logic [15:0] st1, st2, st4, st8;

    // NOTE: every signal written in always_comb is assigned on all paths, so no latch is inferred.
    always_comb begin
        is_left = (a_op_q == OP_ROL) || (a_op_q == OP_SLL);
        rotate  = (a_op_q == OP_ROL) || (a_op_q == OP_ROR);
        net_in  = is_left ? rev16(a_data_q) : a_data_q;
        st1 = a_count_q[0] ? {(rotate ? net_in[0]   : fill_bit),      net_in[15:1]} : net_in;
        st2 = a_count_q[1] ? {(rotate ? st1[1:0]    : {2{fill_bit}}), st1[15:2]}    : st1;
        st4 = a_count_q[2] ? {(rotate ? st2[3:0]    : {4{fill_bit}}), st2[15:4]}    : st2;
        st8 = a_count_q[3] ? {(rotate ? st4[7:0]    : {8{fill_bit}}), st4[15:8]}    : st4;
        shift_d = is_left ? rev16(st8) : st8;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            a_count_q <= '0;
            a_op_q    <= OP_ROL;
            a_tag_q   <= '0;
`ifdef SHIFT_ARITH_EN
            a_arith_q <= 1'b0;
`endif
        end else begin
            if (flush) begin
                a_valid_q <= 1'b0;
            end else if (accept) begin
                a_valid_q <= 1'b1;
            end else if (advance_a) begin
                a_valid_q <= 1'b0;
            end
            if (accept) begin
                a_data_q  <= in_data;
                a_count_q <= in_count;
                a_op_q    <= shift_op_e'(in_op);
                a_tag_q   <= in_tag;
`ifdef SHIFT_ARITH_EN
                a_arith_q <= in_arith;
`endif
            end
        end
    end

    // Output data is loaded even in a flush cycle; the cleared valid bit makes it don't-care.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
            b_tag_q   <= '0;
            b_zero_q  <= 1'b0;
        end else begin
            if (flush) begin
                b_valid_q <= 1'b0;
            end else if (advance_a) begin
                b_valid_q <= 1'b1;
            end else if (out_ready) begin
                b_valid_q <= 1'b0;
            end
            if (advance_a) begin
                b_data_q <= shift_d;
                b_tag_q  <= a_tag_q;
                b_zero_q <= (shift_d == 16'h0000);
            end
        end
    end

    assign out_valid = b_valid_q;
    assign out_data  = b_data_q;
    assign out_tag   = b_tag_q;
    assign out_zero  = b_zero_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Bench for shift_exec_pipe: directed cases followed by random traffic against a reference model.
module tb_shift_exec_pipe;

    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_data = '0;
    logic [3:0]       in_count = '0;
    logic [1:0]       in_op = '0;
    logic             in_arith = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    shift_exec_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_count  (in_count),
        .in_op     (in_op),
        .in_arith  (in_arith),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   errors = 0;
    int   checks = 0;

`ifdef SHIFT_ARITH_EN
    localparam logic [15:0] SRA_EXP = 16'hFFFF;
    localparam bit          ARITH_ON = 1'b1;
`else
    localparam logic [15:0] SRA_EXP = 16'h0001;
    localparam bit          ARITH_ON = 1'b0;
`endif

    // Arithmetic description of each op: rotate = shift OR wrapped-around part.
    function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [3:0] cnt,
                                              input logic [1:0] op, input logic ar);
        logic [31:0] v;
        logic [31:0] res;
        int          c;
        v = {16'h0, x};
        c = int'({28'h0, cnt});
        case (op)
            2'b00:   res = ((v << c) | (v >> (16 - c))) & 32'hFFFF;
            2'b01:   res = (v << c) & 32'hFFFF;
            2'b10:   res = ((v >> c) | (v << (16 - c))) & 32'hFFFF;
            default: begin
                res = v >> c;
                if (ARITH_ON && ar && x[15]) res = res | (32'hFFFF & ~(32'hFFFF >> c));
            end
        endcase
        return res[15:0];
    endfunction

    task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [1:0] op, input logic [15:0] d,
                          input logic [3:0] c, input logic ar, input logic [TAG_W-1:0] t);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_count = c;
        in_arith = ar;
        in_tag   = t;
    endtask

    // Called just after a falling edge with inputs already driven; checks, updates model, crosses one edge.
    task automatic tick();
        logic exp_ov;
        logic exp_rdy;
        exp_t e;
        #1;
        exp_ov  = (q.size() > 0) && (q[0].acc < edge_n);
        exp_rdy = !flush && ((q.size() < 2) || out_ready);
        chk("out_valid", 16'(out_valid), 16'(exp_ov));
        chk("in_ready", 16'(in_ready), 16'(exp_rdy));
        if (exp_ov) begin
            chk("out_data", out_data, q[0].data);
            chk("out_tag", 16'(out_tag), 16'(q[0].tag));
            chk("out_zero", 16'(out_zero), 16'(q[0].data == 16'h0));
            if (out_ready) void'(q.pop_front());
        end
        if (flush) begin
            q.delete();
        end else if (in_valid && exp_rdy) begin
            e.data = ref_shift(in_data, in_count, in_op, in_arith);
            e.tag  = in_tag;
            e.acc  = edge_n + 1;
            q.push_back(e);
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic directed(input string name, input logic [1:0] op, input logic [15:0] d,
                            input logic [3:0] c, input logic ar, input logic [15:0] exp);
        out_ready = 1'b1;
        set_in(1'b1, op, d, c, ar, 3'd5);
        tick();
        set_in(1'b0, 2'b00, 16'h0, 4'd0, 1'b0, 3'd0);
        tick();
        #1;
        chk(name, out_data, exp);
        chk({name, "_zero"}, 16'(out_zero), 16'(exp == 16'h0));
        tick();
    endtask

    initial begin
        #1;
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_tag", 16'(out_tag), 16'h0);
        chk("rst_out_zero", 16'(out_zero), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 16'(in_ready), 16'h1);

        directed("ror_8001_1", 2'b10, 16'h8001, 4'd1, 1'b0, 16'hC000);
        directed("srl_8001_1", 2'b11, 16'h8001, 4'd1, 1'b0, 16'h4000);
        directed("rol_8001_4", 2'b00, 16'h8001, 4'd4, 1'b0, 16'h0018);
        directed("sll_8001_4", 2'b01, 16'h8001, 4'd4, 1'b0, 16'h0010);
        directed("sll_8000_1", 2'b01, 16'h8000, 4'd1, 1'b0, 16'h0000);
        directed("cnt0_rol", 2'b00, 16'hA5C3, 4'd0, 1'b0, 16'hA5C3);
        directed("sra_8000_15", 2'b11, 16'h8000, 4'd15, 1'b1, SRA_EXP);
        directed("sra_4000_14", 2'b11, 16'h4000, 4'd14, 1'b1, 16'h0001);

        // Backpressure: tags 1,2 absorbed, tag 3 stalls until out_ready rises.
        out_ready = 1'b0;
        set_in(1'b1, 2'b10, 16'h0011, 4'd1, 1'b0, 3'd1);
        tick();
        set_in(1'b1, 2'b10, 16'h0022, 4'd1, 1'b0, 3'd2);
        tick();
        set_in(1'b1, 2'b10, 16'h0033, 4'd1, 1'b0, 3'd3);
        #1;
        chk("bp_third_stall", 16'(in_ready), 16'h0);
        tick();
        out_ready = 1'b1;
        tick();
        set_in(1'b0, 2'b00, 16'h0, 4'd0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) tick();

        // Flush with both stages full and a new op offered.
        out_ready = 1'b0;
        set_in(1'b1, 2'b11, 16'h1234, 4'd2, 1'b0, 3'd4);
        tick();
        set_in(1'b1, 2'b11, 16'h5678, 4'd3, 1'b0, 3'd6);
        tick();
        flush = 1'b1;
        set_in(1'b1, 2'b01, 16'h0F0F, 4'd1, 1'b0, 3'd7);
        #1;
        chk("flush_in_ready", 16'(in_ready), 16'h0);
        tick();
        flush = 1'b0;
        set_in(1'b0, 2'b00, 16'h0, 4'd0, 1'b0, 3'd0);
        #1;
        chk("flush_out_valid", 16'(out_valid), 16'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Reset while two ops are in flight.
        out_ready = 1'b0;
        set_in(1'b1, 2'b00, 16'h00FF, 4'd3, 1'b0, 3'd1);
        tick();
        set_in(1'b1, 2'b00, 16'h0F00, 4'd3, 1'b0, 3'd2);
        tick();
        set_in(1'b0, 2'b00, 16'h0, 4'd0, 1'b0, 3'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 16'(out_valid), 16'h0);
        chk("midrst_out_data", out_data, 16'h0000);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("postrst_in_ready", 16'(in_ready), 16'h1);
        directed("ror_0001_15", 2'b10, 16'h0001, 4'd15, 1'b0, 16'h0002);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 2'b00, 16'h0, 4'd0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
